// File: rtl/psg_write_sequencer_if.sv
// Requester handshake and PSG pin bundle for psg_write_sequencer.
// slave: the sequencer side; master: requesters and PSG pins.
interface psg_write_sequencer_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [2:0] req0_reg;
  logic [9:0] req0_data;
  logic       req1_valid;
  logic       req1_ready;
  logic [2:0] req1_reg;
  logic [9:0] req1_data;
  logic [7:0] psg_d;
  logic       psg_ce_n;
  logic       psg_we_n;
  logic       busy;
  logic       last_grant;

  modport slave (
    input  req0_valid,
    input  req0_reg,
    input  req0_data,
    input  req1_valid,
    input  req1_reg,
    input  req1_data,
    output req0_ready,
    output req1_ready,
    output psg_d,
    output psg_ce_n,
    output psg_we_n,
    output busy,
    output last_grant
  );

  modport master (
    output req0_valid,
    output req0_reg,
    output req0_data,
    output req1_valid,
    output req1_reg,
    output req1_data,
    input  req0_ready,
    input  req1_ready,
    input  psg_d,
    input  psg_ce_n,
    input  psg_we_n,
    input  busy,
    input  last_grant
  );
endinterface

// File: rtl/psg_write_sequencer.sv
// SN76489 write sequencer: round-robin over two requesters, latch/data bytes.
// Optional PSG_SEQ_SHADOW_EN skips writes that would not change the chip.
module psg_write_sequencer #(
  parameter int GAP = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clk_en,
  psg_write_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_DATA,
    S_GAP
  } state_t;

  localparam logic [3:0] GAP_N = 4'(GAP);

  state_t     state;
  state_t     state_nx;
  logic [2:0] reg_q;
  logic [2:0] reg_nx;
  logic [9:0] data_q;
  logic [9:0] data_nx;
  logic [3:0] gap_q;
  logic [3:0] gap_nx;
  logic       lg_q;
  logic       lg_nx;
  logic [7:0] d_q;
  logic [7:0] d_nx;

  logic       idle;
  logic       g0;
  logic       g1;
  logic       acc;
  logic       skip;
  logic [2:0] sel_reg;
  logic [9:0] sel_data;

  function automatic logic is_freq(input logic [2:0] r);
    return !r[0] && (r != 3'd6);
  endfunction

  assign idle = (state == S_IDLE);

  // On a tie the requester that did not win last time goes next.
  assign g0 = bus.req0_valid && (!bus.req1_valid || lg_q);
  assign g1 = bus.req1_valid && (!bus.req0_valid || !lg_q);

  assign bus.req0_ready = idle && g0;
  assign bus.req1_ready = idle && g1;
  assign acc            = idle && (g0 || g1);

  assign sel_reg  = g1 ? bus.req1_reg  : bus.req0_reg;
  assign sel_data = g1 ? bus.req1_data : bus.req0_data;

`ifdef PSG_SEQ_SHADOW_EN
  logic [9:0] shadow [8];
  logic       same;

  always_comb begin
    same = 1'b0;
    if (is_freq(sel_reg))
      same = (shadow[sel_reg] == sel_data);
    else
      same = (shadow[sel_reg][3:0] == sel_data[3:0]);
  end

  // Noise control is always written: the write itself reloads the LFSR.
  assign skip = acc && same && (sel_reg != 3'd6);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++)
        shadow[i] <= i[0] ? 10'd15 : 10'd0;
    end else if (acc) begin
      if (is_freq(sel_reg))
        shadow[sel_reg] <= sel_data;
      else
        shadow[sel_reg] <= {6'd0, sel_data[3:0]};
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    reg_nx   = reg_q;
    data_nx  = data_q;
    gap_nx   = gap_q;
    lg_nx    = lg_q;
    d_nx     = d_q;
    unique case (state)
      S_IDLE: begin
        if (acc) begin
          reg_nx  = sel_reg;
          data_nx = sel_data;
          lg_nx   = g1;
          if (!skip) begin
            state_nx = S_LATCH;
            d_nx     = {1'b1, sel_reg, sel_data[3:0]};
          end
        end
      end
      S_LATCH: begin
        if (clk_en) begin
          if (is_freq(reg_q)) begin
            state_nx = S_DATA;
            d_nx     = {2'b00, data_q[9:4]};
          end else begin
            state_nx = (GAP_N == 4'd0) ? S_IDLE : S_GAP;
            gap_nx   = 4'd0;
          end
        end
      end
      S_DATA: begin
        if (clk_en) begin
          state_nx = (GAP_N == 4'd0) ? S_IDLE : S_GAP;
          gap_nx   = 4'd0;
        end
      end
      S_GAP: begin
        if (clk_en) begin
          if (gap_q == GAP_N - 4'd1)
            state_nx = S_IDLE;
          else
            gap_nx = gap_q + 4'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      reg_q  <= 3'd0;
      data_q <= 10'd0;
      gap_q  <= 4'd0;
      lg_q   <= 1'b1;
      d_q    <= 8'd0;
    end else begin
      state  <= state_nx;
      reg_q  <= reg_nx;
      data_q <= data_nx;
      gap_q  <= gap_nx;
      lg_q   <= lg_nx;
      d_q    <= d_nx;
    end
  end

  // Strobes come straight from the state register, so each byte spans
  // exactly one clk_en-qualified edge.
  assign bus.psg_ce_n   = !((state == S_LATCH) || (state == S_DATA));
  assign bus.psg_we_n   = !((state == S_LATCH) || (state == S_DATA));
  assign bus.psg_d      = d_q;
  assign bus.busy       = !idle;
  assign bus.last_grant = lg_q;

endmodule

// File: tb/tb_psg_write_sequencer.sv
// Directed bench for psg_write_sequencer (GAP=2).
// Byte, grant and gap-tick logs are sampled between clock edges.
module tb_psg_write_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clk_en = 1'b0;

  psg_write_sequencer_if bif();

  psg_write_sequencer #(.GAP(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .bus     (bif)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic       en_force = 1'b1;
  logic       en_val = 1'b0;
  logic [1:0] ph = 2'd0;

  logic [7:0] bytes [64];
  int         grants [64];
  int         nbytes = 0;
  int         ngr = 0;
  int         g0c = 0;
  int         g1c = 0;
  int         gap_ticks = 0;
  bit         both_rdy = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    if (en_force) begin
      clk_en = en_val;
    end else begin
      ph = ph + 2'd1;
      clk_en = (ph == 2'd3);
    end
  end

  initial forever begin
    @(negedge clk);
    #3;
    if (!bif.psg_we_n && clk_en) begin
      if (nbytes < 64) bytes[nbytes] = bif.psg_d;
      nbytes++;
    end
    if (bif.busy && bif.psg_we_n && clk_en) gap_ticks++;
    if (bif.req0_ready && bif.req1_ready) both_rdy = 1'b1;
    if (bif.req0_valid && bif.req0_ready) begin
      if (ngr < 64) grants[ngr] = 0;
      ngr++;
      g0c++;
    end
    if (bif.req1_valid && bif.req1_ready) begin
      if (ngr < 64) grants[ngr] = 1;
      ngr++;
      g1c++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic send(input int p,
                      input logic [2:0] r,
                      input logic [9:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    if (p == 0) begin
      bif.req0_reg   = r;
      bif.req0_data  = d;
      bif.req0_valid = 1'b1;
    end else begin
      bif.req1_reg   = r;
      bif.req1_data  = d;
      bif.req1_valid = 1'b1;
    end
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      if ((p == 0) ? bif.req0_ready : bif.req1_ready) ok = 1'b1;
      @(negedge clk);
    end
    bif.req0_valid = 1'b0;
    bif.req1_valid = 1'b0;
    check("accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (!bif.busy) ok = 1'b1;
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  int  b;
  int  gt;
  int  gb;
  int  g0b;
  int  g1b;
  bit  flag;

  initial begin
    bif.req0_valid = 1'b0;
    bif.req0_reg   = 3'd0;
    bif.req0_data  = 10'd0;
    bif.req1_valid = 1'b0;
    bif.req1_reg   = 3'd0;
    bif.req1_data  = 10'd0;

    do_reset();
    check("rst_ce_n", 32'(bif.psg_ce_n), 32'd1);
    check("rst_we_n", 32'(bif.psg_we_n), 32'd1);
    check("rst_d", 32'(bif.psg_d), 32'h00);
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_last_grant", 32'(bif.last_grant), 32'd1);
    check("rst_ready0", 32'(bif.req0_ready), 32'd0);

    en_force = 1'b0;
    b = nbytes;
    gt = gap_ticks;
    send(0, 3'd1, 10'h00A);
    wait_idle();
    check("atten_nbytes", 32'(nbytes - b), 32'd1);
    check("atten_byte", 32'(bytes[b]), 32'h9A);
    check("atten_gap", 32'(gap_ticks - gt), 32'd2);
    check("atten_lg", 32'(bif.last_grant), 32'd0);

    b = nbytes;
    gt = gap_ticks;
    send(1, 3'd2, 10'h3FE);
    wait_idle();
    check("freq_nbytes", 32'(nbytes - b), 32'd2);
    check("freq_latch", 32'(bytes[b]), 32'hAE);
    check("freq_data", 32'(bytes[b+1]), 32'h3F);
    check("freq_gap", 32'(gap_ticks - gt), 32'd2);
    check("freq_lg", 32'(bif.last_grant), 32'd1);

    en_force = 1'b1;
    en_val = 1'b0;
    b = nbytes;
    send(0, 3'd1, 10'h003);
    flag = 1'b1;
    repeat (50) begin
      @(negedge clk);
      #1;
      if (bif.psg_we_n || bif.psg_ce_n || bif.psg_d !== 8'h93) flag = 1'b0;
    end
    check("stall_hold", 32'(flag), 32'd1);
    check("stall_nobyte", 32'(nbytes - b), 32'd0);
    en_val = 1'b1;
    @(negedge clk);
    #1;
    en_val = 1'b0;
    en_force = 1'b0;
    wait_idle();
    check("stall_nbytes", 32'(nbytes - b), 32'd1);
    check("stall_byte", 32'(bytes[b]), 32'h93);

    do_reset();
    b = nbytes;
    gb = ngr;
    g0b = g0c;
    g1b = g1c;
    @(negedge clk);
    bif.req0_reg   = 3'd3;
    bif.req0_data  = 10'h005;
    bif.req1_reg   = 3'd7;
    bif.req1_data  = 10'h009;
    bif.req0_valid = 1'b1;
    bif.req1_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (g0c - g0b >= 1) bif.req0_data = 10'h006;
      if (g1c - g1b >= 1) bif.req1_data = 10'h00A;
      if (ngr - gb >= 4) break;
    end
    bif.req0_valid = 1'b0;
    bif.req1_valid = 1'b0;
    wait_idle();
    check("rr_ngrants", 32'(ngr - gb), 32'd4);
    check("rr_g0", 32'(grants[gb]), 32'd0);
    check("rr_g1", 32'(grants[gb+1]), 32'd1);
    check("rr_g2", 32'(grants[gb+2]), 32'd0);
    check("rr_g3", 32'(grants[gb+3]), 32'd1);
    check("rr_b0", 32'(bytes[b]), 32'hB5);
    check("rr_b1", 32'(bytes[b+1]), 32'hF9);
    check("rr_b2", 32'(bytes[b+2]), 32'hB6);
    check("rr_b3", 32'(bytes[b+3]), 32'hFA);
    check("rr_both_ready", 32'(both_rdy), 32'd0);

    b = nbytes;
    send(1, 3'd0, 10'h123);
    flag = 1'b0;
    for (int i = 0; i < 100 && !flag; i++) begin
      @(negedge clk);
      #1;
      if (!bif.psg_we_n && bif.psg_d == 8'h12) flag = 1'b1;
    end
    check("mid_data_seen", 32'(flag), 32'd1);
    en_force = 1'b1;
    en_val = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    check("mid_ce_n", 32'(bif.psg_ce_n), 32'd1);
    check("mid_we_n", 32'(bif.psg_we_n), 32'd1);
    check("mid_d", 32'(bif.psg_d), 32'h00);
    check("mid_busy", 32'(bif.busy), 32'd0);
    check("mid_lg", 32'(bif.last_grant), 32'd1);
    check("mid_nbytes", 32'(nbytes - b), 32'd1);
    reset_n = 1'b1;
    en_force = 1'b0;
    b = nbytes;
    send(0, 3'd4, 10'h2A5);
    wait_idle();
    check("post_nbytes", 32'(nbytes - b), 32'd2);
    check("post_latch", 32'(bytes[b]), 32'hC5);
    check("post_data", 32'(bytes[b+1]), 32'h2A);

`ifdef PSG_SEQ_SHADOW_EN
    do_reset();
    b = nbytes;
    send(0, 3'd5, 10'h00F);
    wait_idle();
    check("shadow_skip", 32'(nbytes - b), 32'd0);
    check("shadow_lg", 32'(bif.last_grant), 32'd0);
    b = nbytes;
    send(0, 3'd6, 10'h004);
    wait_idle();
    send(0, 3'd6, 10'h004);
    wait_idle();
    check("noise_nbytes", 32'(nbytes - b), 32'd2);
    check("noise_b0", 32'(bytes[b]), 32'hE4);
    check("noise_b1", 32'(bytes[b+1]), 32'hE4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/psg_write_sequencer.md
# psg_write_sequencer

Write-side controller for the SN76489 sound generator. It accepts register-write commands from two requesters (CPU bus glue and the music/sfx player) and arbitrates between them round-robin. Each command is serialized into the PSG's 1- or 2-byte latch/data protocol, and the chip-enable/write strobes are driven so that each byte is seen on exactly one `clk_en`-qualified cycle. The block sits between the requesters and the PSG's `d`/`ce_n`/`we_n` pins and shares the PSG's `clk` and `clk_en`.

## Interface
Parameters:
- `GAP`, default 2: number of `clk_en` ticks idled after the last byte of a command before the next grant. Legal range 0..15.

Ports:
- `clk`  in  1  system clock, same as the PSG.
- `reset_n`  in  1  synchronous, active-low reset.
- `clk_en`  in  1  PSG clock enable, the same strobe wired to the PSG.
- `req0_valid` / `req1_valid`  in  1  command pending.
- `req0_ready` / `req1_ready`  out  1  command accepted this cycle when high together with valid.
- `req0_reg` / `req1_reg`  in  3  PSG register index 0..7.
- `req0_data` / `req1_data`  in  10  value. Bits 9:0 are used for the frequency registers (0, 2, 4); only bits 3:0 are used for all others.
- `psg_d`  out  8  PSG data bus. Bit 7 drives PSG `d[0]` (its MSB), so a direct vector connection is correct.
- `psg_ce_n`  out  1  PSG chip enable.
- `psg_we_n`  out  1  PSG write enable.
- `busy`  out  1  high in every state except IDLE.
- `last_grant`  out  1  index of the most recently accepted requester.

## Operation
- FSM states: IDLE, LATCH, DATA, GAP.
- **IDLE: arbitration.**
  - `reqN_ready` is combinational and high only in IDLE, and only for the winner.
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester ≠ `last_grant` wins.
  - On accept: capture `reg`/`data`, update `last_grant`, go to LATCH.
- **LATCH:** `psg_d = {1'b1, reg[2:0], data[3:0]}`.
  - On a cycle with `clk_en=1`, go to DATA if `reg ∈ {0,2,4}`, otherwise go to GAP (or IDLE if `GAP==0`).
- **DATA:** `psg_d = {2'b00, data[9:4]}`.
  - On a cycle with `clk_en=1`, go to GAP (or IDLE if `GAP==0`).
- **GAP:** a 4-bit counter counts `clk_en` ticks. After `GAP` ticks, go to IDLE.
- **Strobes:** `psg_ce_n = psg_we_n = 0` exactly while in LATCH or DATA, decoded directly from the state register. This guarantees the strobe spans exactly one `clk_en=1` cycle per byte.
- `psg_d` holds its last value outside LATCH/DATA.
- **Reset:** on `reset_n=0` at a clock edge:
  - state = IDLE, `psg_ce_n = psg_we_n = 1`, `psg_d = 0`, `busy = 0`, `last_grant = 1` (req0 wins the first tie), GAP counter = 0.
  - An in-flight command is dropped. A frequency command cut between bytes leaves the PSG with only the low nibble updated, which is acceptable.

## Timing
- Accept edge (`valid && ready`) to `psg_we_n` low: 1 cycle.
- A byte completes on the first edge where `clk_en=1` in LATCH/DATA.
  - With `clk_en` stuck low, the strobe stays asserted indefinitely and no spurious second byte occurs.
- Command throughput:
  - Minimum 1 + 1 `clk_en` + `GAP` `clk_en` ticks + 1 cycle back in IDLE for single-byte commands.
  - Frequency commands take one more `clk_en`.
- `ready` is never high outside IDLE. A requester must hold `valid`, `reg` and `data` stable until `ready`.
- A request arriving in the same cycle the FSM returns to IDLE is eligible immediately.
- Only one requester can be granted per cycle.

## Configuration
- Macro `PSG_SEQ_SHADOW_EN`, defined:
  - The block keeps an 8×10 shadow of the last written values, reset to match the PSG: odd registers = 15, even registers = 0.
  - An accepted command whose `data` equals the shadow entry is completed without any bus cycle (IDLE→IDLE, no strobe). Only bits 3:0 are compared for non-frequency registers.
  - Register 6 (noise control) is always written, because a write reloads the noise LFSR.
  - The shadow updates on accept. If a reset aborts the command, the shadow is reinitialised anyway.
- Macro undefined:
  - No shadow logic; every command is written.

## Test plan
- **Single attenuation write:** req0 `reg=1`, `data=0x00A`, `clk_en` every 4th cycle → exactly one strobe with `psg_d=8'h9A`, spanning one `clk_en` cycle; `busy` returns low after 2 further `clk_en` ticks (`GAP=2`).
- **Frequency write:** req1 `reg=2`, `data=0x3FE` → `psg_d=8'hAE` strobe, then `8'h3F` strobe; exactly 2 `clk_en`-qualified write cycles.
- **Round-robin:** both valid continuously with distinct commands → grants alternate 0,1,0,1 starting with req0 after reset; `ready` is never high for both at once.
- **Stall:** `clk_en` held low for 50 cycles during LATCH → strobe stays low and `psg_d` is stable; one byte is taken when `clk_en` rises.
- **Reset mid-operation:** `reset_n` low during DATA of a frequency write → next cycle `psg_ce_n=psg_we_n=1`, `psg_d=0`, `busy=0`; a new command then proceeds normally.
- **Shadow (with `PSG_SEQ_SHADOW_EN`):**
  - `reg=5`, `data=0x00F` right after reset → no strobe.
  - `reg=6`, `data=0x004`, written twice → two strobes.
